aes_ecb_dec_ctrl: RTL and testbench

Sequencer between the AXI4-Lite register bank of the AES ECB interrupt-driven decrypt peripheral and the AES-128 decrypt core. It snapshots key and ciphertext on a software start and runs key expansion only when the key changed. It then launches one block decryption, captures the plaintext, and drives sticky status plus a level interrupt. A watchdog aborts a hung core.

---
 rtl/aes_ecb_dec_ctrl.sv | 177 +++++++++++++++++
 tb/tb_aes_ecb_dec_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ecb_dec_ctrl.sv
// Sequencer between the AES-ECB decrypt register bank and an AES-128 decrypt
// core. It skips key expansion when the key is unchanged, runs one block, and
// reports through sticky status bits, a level interrupt and a watchdog.
module aes_ecb_dec_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 11
) (
  input  logic         ACLK,
  input  logic         ARESET,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic         irq_en_i,
  input  logic         irq_clr_i,
  input  logic [127:0] key_i,
  input  logic [127:0] ct_i,
  output logic [127:0] core_key,
  output logic [127:0] core_din,
  output logic         core_key_load,
  input  logic         core_key_ready,
  output logic         core_start,
  input  logic         core_done,
  input  logic [127:0] core_dout,
  output logic [127:0] pt_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic         ovr_o,
  output logic         irq_o
);

  typedef enum logic [2:0] {
    IDLE,
    KEY_LOAD,
    KEY_WAIT,
    DATA_START,
    DATA_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] WDOG_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] WDOG_MAX   = '1;

  state_t             state, state_nxt;
  logic               key_valid;
  logic [127:0]       cached_key;
  logic [CNT_W-1:0]   wdog;

  // Control strobes decoded from the FSM, consumed by the datapath registers.
  logic latch_in, key_accept, pt_capture;
  logic wdog_clr, wdog_inc;
  logic set_done, set_err, set_ovr, kv_clr;
  logic timeout;

  assign timeout = (wdog == WDOG_LIMIT);
  assign busy_o  = (state != IDLE);
  assign set_ovr = start_i && (state != IDLE);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and one-cycle core strobes; abort overrides everything.
  // NOTE: every signal driven here gets a default first, otherwise a path that
  // leaves it unassigned would infer a latch.
  always_comb begin
    state_nxt     = state;
    latch_in      = 1'b0;
    key_accept    = 1'b0;
    pt_capture    = 1'b0;
    wdog_clr      = 1'b0;
    wdog_inc      = 1'b0;
    set_done      = 1'b0;
    set_err       = 1'b0;
    kv_clr        = 1'b0;
    core_key_load = 1'b0;
    core_start    = 1'b0;
    if (abort_i) begin
      state_nxt = IDLE;
      kv_clr    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            latch_in  = 1'b1;
            state_nxt = (!key_valid || (key_i != cached_key)) ? KEY_LOAD : DATA_START;
          end
        end
        KEY_LOAD: begin
          core_key_load = 1'b1;
          wdog_clr      = 1'b1;
          state_nxt     = KEY_WAIT;
        end
        KEY_WAIT: begin
          if (core_key_ready) begin
            key_accept = 1'b1;
            state_nxt  = DATA_START;
          end else if (timeout) begin
            set_err   = 1'b1;
            kv_clr    = 1'b1;
            state_nxt = IDLE;
          end else begin
            wdog_inc = 1'b1;
          end
        end
        DATA_START: begin
          core_start = 1'b1;
          wdog_clr   = 1'b1;
          state_nxt  = DATA_WAIT;
        end
        DATA_WAIT: begin
          if (core_done) begin
            pt_capture = 1'b1;
            set_done   = 1'b1;
            state_nxt  = IDLE;
          end else if (timeout) begin
            set_err   = 1'b1;
            kv_clr    = 1'b1;
            state_nxt = IDLE;
          end else begin
            wdog_inc = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Operand snapshot, key cache and plaintext capture.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      core_key   <= '0;
      core_din   <= '0;
      cached_key <= '0;
      key_valid  <= 1'b0;
      pt_o       <= '0;
    end else begin
      if (latch_in) begin
        core_key <= key_i;
        core_din <= ct_i;
      end
      if (key_accept) cached_key <= core_key;
      if (kv_clr)          key_valid <= 1'b0;
      else if (key_accept) key_valid <= 1'b1;
      if (pt_capture) pt_o <= core_dout;
    end
  end

  // Saturating watchdog, cleared whenever a core request is issued.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wdog <= '0;
    end else if (wdog_clr) begin
      wdog <= '0;
    end else if (wdog_inc && (wdog != WDOG_MAX)) begin
      wdog <= wdog + CNT_W'(1);
    end
  end

  // Sticky status (set beats clear) and the registered interrupt level.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      ovr_o  <= 1'b0;
      irq_o  <= 1'b0;
    end else begin
      done_o <= (done_o && !irq_clr_i) || set_done;
      err_o  <= (err_o  && !irq_clr_i) || set_err;
      ovr_o  <= (ovr_o  && !irq_clr_i) || set_ovr;
      irq_o  <= (done_o || err_o) && irq_en_i;
    end
  end

endmodule

// File: tb/tb_aes_ecb_dec_ctrl.sv
// Bench for aes_ecb_dec_ctrl: directed runs against a behavioural core model,
// with a scoreboard queue of expected completions checked by a monitor.
module tb_aes_ecb_dec_ctrl;

  localparam logic [127:0] K1     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2     = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] CT1    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT2    = 128'hffffffff00000000ffffffff00000000;
  localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT_C2K1 = 128'hfffefdfc04050607f7f6f5f40c0d0e0f;
  localparam logic [127:0] PT_C1K2 = 128'h66caedd461710d38dfcbb28473b6c45a;
  localparam logic [127:0] PT_C2K2 = 128'hf0f1f2f30b0a0908f8f9fafb03020100;

  typedef struct {
    logic [127:0] pt;
    logic         done;
    logic         err;
    logic         ovr;
    int           loads;
    int           starts;
  } exp_t;

  logic         ACLK;
  logic         ARESET;
  logic         start_i = 1'b0;
  logic         abort_i = 1'b0;
  logic         irq_en_i = 1'b0;
  logic         irq_clr_i = 1'b0;
  logic [127:0] key_i = '0;
  logic [127:0] ct_i = '0;
  logic [127:0] core_key, core_din, pt_o;
  logic         core_key_load, core_start;
  logic         core_key_ready = 1'b0;
  logic         core_done = 1'b0;
  logic [127:0] core_dout = '0;
  logic         busy_o, done_o, err_o, ovr_o, irq_o;

  logic         hang = 1'b0;
  int           kr_cnt = 0;
  int           dn_cnt = 0;
  logic [127:0] m_din = '0;
  logic [127:0] m_key = '0;

  int   n_checks = 0;
  int   n_pass = 0;
  exp_t exp_q[$];

  aes_ecb_dec_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .irq_en_i      (irq_en_i),
    .irq_clr_i     (irq_clr_i),
    .key_i         (key_i),
    .ct_i          (ct_i),
    .core_key      (core_key),
    .core_din      (core_din),
    .core_key_load (core_key_load),
    .core_key_ready(core_key_ready),
    .core_start    (core_start),
    .core_done     (core_done),
    .core_dout     (core_dout),
    .pt_o          (pt_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .ovr_o         (ovr_o),
    .irq_o         (irq_o)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  function automatic logic [127:0] model_pt(input logic [127:0] din, input logic [127:0] key);
    if (din == CT1 && key == K1) return PT_FIPS;
    return din ^ key;
  endfunction

  // Core model: key ready 6 cycles after the load pulse, block done 12 cycles
  // after core_start (never, when hang is set). It ignores ARESET on purpose.
  always @(posedge ACLK) begin
    core_key_ready <= 1'b0;
    core_done      <= 1'b0;
    if (core_key_load) begin
      kr_cnt <= 5;
    end else if (kr_cnt != 0) begin
      kr_cnt <= kr_cnt - 1;
      if (kr_cnt == 1) core_key_ready <= 1'b1;
    end
    if (core_start) begin
      dn_cnt <= 11;
      m_din  <= core_din;
      m_key  <= core_key;
    end else if (dn_cnt != 0) begin
      dn_cnt <= dn_cnt - 1;
      if (dn_cnt == 1 && !hang) begin
        core_done <= 1'b1;
        core_dout <= model_pt(m_din, m_key);
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic expect_op(input logic [127:0] pt, input logic done, input logic err,
                           input logic ovr, input int loads, input int starts);
    exp_t e;
    e.pt = pt; e.done = done; e.err = err; e.ovr = ovr; e.loads = loads; e.starts = starts;
    exp_q.push_back(e);
  endtask

  // Monitor: counts core pulses per operation and scores each busy fall.
  initial begin : monitor
    logic prev_busy;
    int   n_loads;
    int   n_starts;
    exp_t e;
    prev_busy = 1'b0;
    n_loads   = 0;
    n_starts  = 0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        prev_busy = 1'b0;
        n_loads   = 0;
        n_starts  = 0;
      end else begin
        if (core_key_load) n_loads++;
        if (core_start)    n_starts++;
        if (prev_busy && !busy_o) begin
          check("sb_pending", 128'(exp_q.size() != 0), 128'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_pt",     pt_o,             e.pt);
            check("sb_done",   128'(done_o),     128'(e.done));
            check("sb_err",    128'(err_o),      128'(e.err));
            check("sb_ovr",    128'(ovr_o),      128'(e.ovr));
            check("sb_loads",  128'(n_loads),    128'(e.loads));
            check("sb_starts", 128'(n_starts),   128'(e.starts));
          end
          n_loads  = 0;
          n_starts = 0;
        end
        prev_busy = busy_o;
      end
    end
  end

  task automatic do_start(input logic [127:0] k, input logic [127:0] c);
    @(posedge ACLK); #1;
    key_i   = k;
    ct_i    = c;
    start_i = 1'b1;
    @(posedge ACLK); #1;
    start_i = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge ACLK); #1;
    irq_clr_i = 1'b1;
    @(posedge ACLK); #1;
    irq_clr_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(negedge ACLK);
      n++;
      if (!busy_o) break;
    end
    check("idle_reached", 128'(busy_o), 128'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      128'(busy_o),        128'd0);
    check({tag, "_done"},      128'(done_o),        128'd0);
    check({tag, "_err"},       128'(err_o),         128'd0);
    check({tag, "_ovr"},       128'(ovr_o),         128'd0);
    check({tag, "_irq"},       128'(irq_o),         128'd0);
    check({tag, "_pt"},        pt_o,                128'd0);
    check({tag, "_core_key"},  core_key,            128'd0);
    check({tag, "_core_din"},  core_din,            128'd0);
    check({tag, "_key_load"},  128'(core_key_load), 128'd0);
    check({tag, "_start"},     128'(core_start),    128'd0);
  endtask

  initial begin : stimulus
    int n;
    ARESET = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    check_reset_outputs("rst");
    ARESET   = 1'b0;
    irq_en_i = 1'b1;

    // FIPS-197 block with a fresh key.
    expect_op(PT_FIPS, 1'b1, 1'b0, 1'b0, 1, 1);
    do_start(K1, CT1);
    check("fips_busy", 128'(busy_o), 128'd1);
    check("fips_key_load", 128'(core_key_load), 128'd1);
    wait_idle(100, n);
    @(posedge ACLK); #1;
    check("fips_irq", 128'(irq_o), 128'd1);

    // Clear, then same key: no key load, core_start one cycle after start.
    pulse_clr();
    check("clr_done", 128'(done_o), 128'd0);
    @(posedge ACLK); #1;
    check("clr_irq", 128'(irq_o), 128'd0);
    expect_op(PT_C2K1, 1'b1, 1'b0, 1'b0, 0, 1);
    do_start(K1, CT2);
    check("cached_start", 128'(core_start), 128'd1);
    check("cached_no_load", 128'(core_key_load), 128'd0);
    wait_idle(100, n);

    // Hung core: watchdog fires, plaintext kept, key must be reloaded after.
    hang = 1'b1;
    expect_op(PT_C2K1, 1'b1, 1'b1, 1'b0, 0, 1);
    do_start(K1, CT1);
    check("hang_start", 128'(core_start), 128'd1);
    wait_idle(40, n);
    check("timeout_latency", 128'(n), 128'd19);
    hang = 1'b0;
    expect_op(PT_FIPS, 1'b1, 1'b1, 1'b0, 1, 1);
    do_start(K1, CT1);
    check("reload_after_err", 128'(core_key_load), 128'd1);
    wait_idle(100, n);
    pulse_clr();
    check("clr_all", 128'({done_o, err_o, ovr_o}), 128'd0);

    // Start while busy: overrun flagged, running block unaffected.
    expect_op(PT_C2K1, 1'b1, 1'b0, 1'b1, 0, 1);
    do_start(K1, CT2);
    repeat (4) @(posedge ACLK);
    do_start(K1, CT1);
    check("ovr_din_held", core_din, CT2);
    wait_idle(100, n);
    pulse_clr();

    // Clear in the same cycle as core_done; interrupt masked then unmasked.
    irq_en_i = 1'b0;
    expect_op(PT_FIPS, 1'b1, 1'b0, 1'b0, 0, 1);
    do_start(K1, CT1);
    repeat (12) @(posedge ACLK);
    #1;
    irq_clr_i = 1'b1;
    check("clr_align_core_done", 128'(core_done), 128'd1);
    @(posedge ACLK); #1;
    irq_clr_i = 1'b0;
    check("set_beats_clr", 128'(done_o), 128'd1);
    wait_idle(10, n);
    @(posedge ACLK); #1;
    check("masked_irq", 128'(irq_o), 128'd0);
    irq_en_i = 1'b1;
    @(posedge ACLK); #1;
    check("unmasked_irq", 128'(irq_o), 128'd1);
    check("unmask_done_kept", 128'(done_o), 128'd1);

    // Asynchronous reset during KEY_WAIT; next start must reload the key.
    do_start(K2, CT1);
    check("k2_key_load", 128'(core_key_load), 128'd1);
    repeat (2) @(posedge ACLK);
    #3;
    ARESET = 1'b1;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    repeat (6) @(posedge ACLK);
    expect_op(PT_C1K2, 1'b1, 1'b0, 1'b0, 1, 1);
    do_start(K2, CT1);
    check("reload_after_rst", 128'(core_key_load), 128'd1);
    wait_idle(100, n);

    // Abort during DATA_WAIT: idle next cycle, sticky bits and pt kept.
    expect_op(PT_C1K2, 1'b1, 1'b0, 1'b0, 0, 1);
    do_start(K2, CT2);
    check("abort_run_start", 128'(core_start), 128'd1);
    repeat (3) @(posedge ACLK);
    #1;
    abort_i = 1'b1;
    @(posedge ACLK); #1;
    abort_i = 1'b0;
    check("abort_busy", 128'(busy_o), 128'd0);
    repeat (15) @(posedge ACLK);
    #1;
    check("abort_pt_kept", pt_o, PT_C1K2);
    start_i = 1'b1;
    abort_i = 1'b1;
    @(posedge ACLK); #1;
    start_i = 1'b0;
    abort_i = 1'b0;
    check("abort_beats_start", 128'(busy_o), 128'd0);
    expect_op(PT_C2K2, 1'b1, 1'b0, 1'b0, 1, 1);
    do_start(K2, CT2);
    check("reload_after_abort", 128'(core_key_load), 128'd1);
    wait_idle(100, n);

    repeat (2) @(negedge ACLK);
    check("sb_drained", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
